f_add_sched: RTL and testbench

Round-robin scheduler that shares one pipelined floating-point adder (`iob_fp_add`) between `NREQ` requesters. It runs a valid/ready handshake per requester and issues at most one operand pair per cycle. Each operation carries a tag through a delay line matched to the adder latency, so every result comes back with the id of the requester that issued it. It sits between several Versat units needing occasional FP adds and a single adder instance, which saves area compared with one adder per unit.

---
 rtl/f_add_pkg.sv | 14 +
 rtl/f_add_sched_rr_arbiter.sv | 26 ++
 rtl/iob_fp_add.sv | 109 ++++++++++
 rtl/f_add_sched.sv | 115 +++++++++++
 tb/tb_f_add_sched.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/f_add_pkg.sv
// f_add_pkg: shared constants for the FP-add scheduler and the Versat F_Add
// unit configuration.
//   FADD_LATENCY : pipeline depth of the shared iob_fp_add instance
//   id_w()       : width of a requester id for a given requester count
package f_add_pkg;

    localparam int FADD_LATENCY = 5;

    // Requester id width; a single requester still gets a 1-bit id.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/f_add_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req  : request vector
//   ptr  : highest-priority index; search runs upward from it, wrapping
//   gnt  : one-hot grant, zero when no request
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt
);

    logic [2*NREQ-1:0] dbl, back;
    logic [NREQ-1:0]   rot, pick;

    always_comb begin
        // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
        dbl  = {req, req} >> ptr;
        rot  = dbl[NREQ-1:0];
        pick = rot & (~rot + NREQ'(1));
        back = {pick, pick} << ptr;
        gnt  = back[2*NREQ-1:NREQ];
    end

endmodule

// File: rtl/iob_fp_add.sv
// iob_fp_add: pipelined IEEE-754 adder, one operand pair accepted per cycle.
// The sum is computed combinationally from the operand inputs and then
// delayed through LATENCY register stages.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i             : operand pair valid; done_o is start_i delayed
//   op_a_i, op_b_i      : operands
//   res_o               : sum
//   overflow_o          : result exponent saturated to infinity
//   underflow_o         : result too small, flushed to zero
//   exception_o         : an operand was Inf/NaN; result is a quiet NaN
// Subnormal inputs are treated as zero; rounding truncates.
module iob_fp_add #(
    parameter int DATA_W  = 32,
    parameter int EXP_W   = 8,
    parameter int LATENCY = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              done_o,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic [DATA_W-1:0] res_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              exception_o
);

    localparam int MAN_W = DATA_W - EXP_W - 1;
    // carry + hidden bit + mantissa + 3 guard bits
    localparam int SUM_W = MAN_W + 5;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    logic [DATA_W-1:0] big, sml;
    logic [EXP_W-1:0]  dexp;
    logic [MAN_W:0]    mb, ms;
    logic [SUM_W-2:0]  al;
    logic [SUM_W-1:0]  sum;
    logic [MAN_W-1:0]  man;
    int                lead, e_res;
    logic [DATA_W-1:0] res_c;
    logic              ovf_c, unf_c, exc_c;

    always_comb begin
        // Order by magnitude so the difference is never negative.
        if (op_a_i[DATA_W-2:0] >= op_b_i[DATA_W-2:0]) begin
            big = op_a_i;
            sml = op_b_i;
        end else begin
            big = op_b_i;
            sml = op_a_i;
        end
        mb   = (big[DATA_W-2:MAN_W] == '0) ? '0 : {1'b1, big[MAN_W-1:0]};
        ms   = (sml[DATA_W-2:MAN_W] == '0) ? '0 : {1'b1, sml[MAN_W-1:0]};
        dexp = big[DATA_W-2:MAN_W] - sml[DATA_W-2:MAN_W];
        al   = {ms, 3'b000} >> dexp;
        if (big[DATA_W-1] == sml[DATA_W-1])
            sum = {1'b0, mb, 3'b000} + {1'b0, al};
        else
            sum = {1'b0, mb, 3'b000} - {1'b0, al};
        lead = 0;
        for (int i = 0; i < SUM_W; i++)
            if (sum[i]) lead = i;
        // Leading one normally sits at MAN_W+3; each position off moves the exponent.
        e_res = int'(big[DATA_W-2:MAN_W]) + lead - (MAN_W + 3);
        // Shift the leading one to the top bit, then drop it and the guard bits.
        man   = MAN_W'((sum << (SUM_W - 1 - lead)) >> 4);
        res_c = {big[DATA_W-1], e_res[EXP_W-1:0], man};
        ovf_c = 1'b0;
        unf_c = 1'b0;
        exc_c = 1'b0;
        if (big[DATA_W-2:MAN_W] == EXP_MAX || sml[DATA_W-2:MAN_W] == EXP_MAX) begin
            exc_c = 1'b1;
            res_c = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (sum == '0) begin
            res_c = '0;
        end else if (e_res <= 0) begin
            unf_c = 1'b1;
            res_c = '0;
        end else if (e_res >= int'(EXP_MAX)) begin
            ovf_c = 1'b1;
            res_c = {big[DATA_W-1], EXP_MAX, {MAN_W{1'b0}}};
        end
    end

    logic [LATENCY-1:0]                vld_pipe;
    logic [LATENCY-1:0][DATA_W+2:0]    dat_pipe;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= start_i;
            dat_pipe[0] <= {exc_c, ovf_c, unf_c, res_c};
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign done_o      = vld_pipe[LATENCY-1];
    assign exception_o = dat_pipe[LATENCY-1][DATA_W+2];
    assign overflow_o  = dat_pipe[LATENCY-1][DATA_W+1];
    assign underflow_o = dat_pipe[LATENCY-1][DATA_W];
    assign res_o       = dat_pipe[LATENCY-1][DATA_W-1:0];

endmodule

// File: rtl/f_add_sched.sv
// f_add_sched: shares one pipelined FP adder between NREQ requesters.
// Round-robin grant, one accept per cycle; a {valid,id} tag line matched to
// the adder latency labels each result with its requester.
//   clk, rst            : clock, asynchronous active-high reset
//   en                  : grant enable (in-flight work still drains when low)
//   req_valid/req_ready : per-requester handshake, req_ready one-hot or zero
//   req_a, req_b        : packed operands, requester i at [i*DATA_W +: DATA_W]
//   res_valid/id/data   : one-cycle result strobe, requester id, sum (0 if idle)
//   busy, inflight      : operations issued and not yet returned
module f_add_sched
    import f_add_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NREQ     = 4,
    parameter int LATENCY  = FADD_LATENCY,
    localparam int ID_W    = id_w(NREQ),
    localparam int CNT_W   = $clog2(LATENCY + 2)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic                   res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic [DATA_W-1:0]      res_data,
    output logic                   busy,
    output logic [CNT_W-1:0]       inflight
);

    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   ptr, gnt_id, iss_id;
    logic [DATA_W-1:0] sel_a, sel_b, op_a, op_b, add_res;
    logic              accept, iss_v;
    logic [LATENCY-1:0]           vld_pipe;
    logic [LATENCY-1:0][ID_W-1:0] id_pipe;
    logic [3:0]        fadd_unused;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign req_ready = (en && !rst) ? gnt : '0;
    assign accept    = |req_ready;

    always_comb begin
        gnt_id = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_id = ID_W'(i);
                sel_a  = req_a[i*DATA_W +: DATA_W];
                sel_b  = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            iss_v    <= 1'b0;
            iss_id   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            vld_pipe <= '0;
            id_pipe  <= '0;
            inflight <= '0;
        end else begin
            iss_v <= accept;
            if (accept) begin
                ptr    <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
                iss_id <= gnt_id;
                op_a   <= sel_a;
                op_b   <= sel_b;
            end
            vld_pipe[0] <= iss_v;
            id_pipe[0]  <= iss_id;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
            // Bounded by LATENCY+1 since results retire in accept order.
            case ({accept, res_valid})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Adder always runs; only tag-valid slots are ever presented.
    iob_fp_add #(.DATA_W(DATA_W), .EXP_W(8), .LATENCY(LATENCY)) u_fadd (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (1'b1),
        .done_o      (fadd_unused[0]),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .res_o       (add_res),
        .overflow_o  (fadd_unused[1]),
        .underflow_o (fadd_unused[2]),
        .exception_o (fadd_unused[3])
    );

    assign res_valid = vld_pipe[LATENCY-1];
    assign res_id    = id_pipe[LATENCY-1];
    assign res_data  = res_valid ? add_res : '0;
    assign busy      = (inflight != '0);

endmodule

// File: tb/tb_f_add_sched.sv
// Directed bench for f_add_sched with default parameters (4 requesters,
// latency 5, single precision).
module tb_f_add_sched;

    localparam logic [31:0] F1 = 32'h3F800000;
    localparam logic [31:0] F2 = 32'h40000000;
    localparam logic [31:0] F3 = 32'h40400000;
    localparam logic [31:0] F4 = 32'h40800000;

    logic         clk = 1'b0;
    logic         rst, en;
    logic [3:0]   req_valid, req_ready;
    logic [127:0] req_a, req_b;
    logic         res_valid, busy;
    logic [1:0]   res_id;
    logic [31:0]  res_data;
    logic [2:0]   inflight;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int peak = 0;
    int q_id[$];
    logic [31:0] q_dat[$];
    int q_cyc[$];
    logic [31:0] t2_exp [4];

    f_add_sched dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .busy(busy), .inflight(inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and log whatever the DUT presents after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (res_valid) begin
            q_id.push_back(int'(res_id));
            q_dat.push_back(res_data);
            q_cyc.push_back(cyc);
        end
        if (int'(inflight) > peak) peak = int'(inflight);
    endtask

    task automatic q_clear();
        q_id.delete();
        q_dat.delete();
        q_cyc.delete();
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0;
        t2_exp = '{F2, F3, F4, F1};
        #3;
        chk("rst_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inflight", inflight, 0);
        req_valid = 4'h0;
        tick(); tick(); rst = 1'b0; tick();

        // single request from requester 2: 1.0 + 2.0
        set_op(2, F1, F2); req_valid = 4'b0100; #1;
        chk("t1_ready", req_ready, 4'b0100);
        chk("t1_inflight0", inflight, 0);
        tick(); req_valid = 4'b0000; #1;
        chk("t1_inflight1", inflight, 1);
        chk("t1_busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t1_no_early", res_valid, 0);
            chk("t1_data_zero", res_data, 0);
        end
        tick();
        chk("t1_res_valid", res_valid, 1);
        chk("t1_res_id", res_id, 2);
        chk("t1_res_data", res_data, F3);
        chk("t1_inflight_hold", inflight, 1);
        tick();
        chk("t1_res_drop", res_valid, 0);
        chk("t1_inflight_end", inflight, 0);
        chk("t1_busy_end", busy, 0);

        // all four from reset, each drops once accepted
        rst = 1'b1; tick(); rst = 1'b0;
        set_op(0, F1, F1); set_op(1, F1, F2); set_op(2, F1, F3); set_op(3, F1, 32'h0);
        q_clear(); peak = 0; req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_grant", req_ready, 32'(1 << k));
            tick();
            req_valid[k] = 1'b0;
        end
        #1;
        chk("t2_ready_idle", req_ready, 0);
        repeat (8) tick();
        chk("t2_nres", q_id.size(), 4);
        for (int k = 0; k < 4 && k < q_id.size(); k++) begin
            chk("t2_id", q_id[k], k);
            chk("t2_data", q_dat[k], t2_exp[k]);
        end
        if (q_cyc.size() == 4) chk("t2_consecutive", q_cyc[3] - q_cyc[0], 3);
        chk("t2_peak", peak, 4);
        chk("t2_inflight_end", inflight, 0);

        // requesters 0 and 2 always valid: alternate
        set_op(0, F1, F1); set_op(2, F2, F2); req_valid = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_grant", req_ready, (k % 2 == 0) ? 4'b0001 : 4'b0100);
            tick();
        end
        req_valid = 4'b0000;
        repeat (8) tick();

        // requester 1 back-to-back for 10 cycles
        set_op(1, F1, F2); q_clear(); peak = 0; req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t4_grant", req_ready, 4'b0010);
            tick();
        end
        req_valid = 4'b0000;
        repeat (8) tick();
        chk("t4_nres", q_id.size(), 10);
        if (q_cyc.size() == 10) begin
            chk("t4_consecutive", q_cyc[9] - q_cyc[0], 9);
            chk("t4_id", q_id[5], 1);
            chk("t4_data", q_dat[9], F3);
        end
        chk("t4_peak", peak, 6);

        // enable drops with 3 in flight
        set_op(0, F2, F2); q_clear(); req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_grant", req_ready, 4'b0001);
            tick();
        end
        en = 1'b0; #1;
        chk("t5_ready_off", req_ready, 0);
        chk("t5_inflight", inflight, 3);
        chk("t5_busy", busy, 1);
        repeat (5) tick();
        chk("t5_last_res", res_valid, 1);
        chk("t5_last_data", res_data, F4);
        chk("t5_busy_last", busy, 1);
        tick();
        chk("t5_res_done", res_valid, 0);
        chk("t5_busy_drop", busy, 0);
        chk("t5_inflight_end", inflight, 0);
        chk("t5_ready_still_off", req_ready, 0);
        chk("t5_nres", q_id.size(), 3);
        req_valid = 4'b0000; en = 1'b1;

        // reset two cycles after two accepts
        set_op(1, F1, F1); set_op(2, F1, F1); req_valid = 4'b0110; #1;
        chk("t6_grant1", req_ready, 4'b0010);
        tick(); #1;
        chk("t6_grant2", req_ready, 4'b0100);
        tick(); req_valid = 4'b0000;
        tick(); tick();
        q_clear(); rst = 1'b1; req_valid = 4'b1001; #1;
        chk("t6_rst_inflight", inflight, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", req_ready, 0);
        chk("t6_rst_res", res_valid, 0);
        tick(); rst = 1'b0; req_valid = 4'b0000;
        repeat (8) tick();
        chk("t6_no_stale", q_id.size(), 0);
        set_op(0, F2, F1); set_op(3, F1, F1); req_valid = 4'b1001; #1;
        chk("t6_ptr_reset", req_ready, 4'b0001);
        tick(); req_valid = 4'b0000;
        repeat (7) tick();
        chk("t6_nres", q_id.size(), 1);
        if (q_id.size() == 1) begin
            chk("t6_id", q_id[0], 0);
            chk("t6_data", q_dat[0], F3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
